voq_output_arbiter: RTL and testbench
=====================================

// Module: voq_output_arbiter
// PURPOSE
// - Downstream stage of the VOQ write path: one instance per output port j. Drains the NUM_IN VOQ RAMs
//   holding traffic for output j (input_ram_*[i][j]) one whole packet at a time, round-robin over inputs.
// - Packet in RAM = nonzero header word (port in [1:0]), zero or more nonzero words, then one zero
//   terminator word. Emits a valid/ready word stream tagged with source input and end-of-packet.
// PARAMETERS
// - NUM_IN      4   number of VOQs (input ports) served
// - DATA_W      32  RAM word width
// - ADDR_W      12  RAM address width; pointers wrap modulo 2**ADDR_W
// - SKID_DEPTH  4   output skid FIFO entries (>=2)
// PORTS
// - clk          in   1               system clock
// - reset_n      in   1               asynchronous reset, active low
// - rams_clear   in   1               sync pulse; VOQ write pointers being zeroed this cycle
// - voq_wr_add   in   NUM_IN*ADDR_W   write pointer of each VOQ (next address to be written)
// - voq_q        in   NUM_IN*DATA_W   RAM read data, valid 1 cycle after rden
// - voq_rd_add   out  NUM_IN*ADDR_W   RAM read address per VOQ
// - voq_rden     out  NUM_IN          RAM read enable per VOQ (at most one high per cycle)
// - out_data     out  DATA_W          stream word
// - out_src      out  $clog2(NUM_IN)  input index the word came from
// - out_eop      out  1               word is the zero terminator
// - out_valid    out  1               word available
// - out_ready    in   1               consumer accepts word when valid&&ready
// BEHAVIOUR
// - Reset: all read/issue pointers 0, FSM IDLE, rr pointer 0, skid empty; voq_rden=0, voq_rd_add=0,
//   out_valid=0, out_data=0, out_src=0, out_eop=0.
// - Per VOQ: commit_ptr (first unconsumed word) and issue_ptr (next address to read); voq_rd_add[i]=issue_ptr[i].
// - VOQ i non-empty when commit_ptr[i] != voq_wr_add[i]; word available for issue when issue_ptr[i] != voq_wr_add[i].
// - FSM IDLE: pick first non-empty VOQ scanning rr+0..rr+NUM_IN-1 (mod NUM_IN); latch grant, -> STREAM next
//   cycle. No non-empty VOQ: stay IDLE.
// - STREAM: assert voq_rden[grant] iff word available for issue && (skid_count+inflight) < SKID_DEPTH;
//   issue_ptr++ on each read. Returned word (next cycle) pushed to skid with src=grant, eop=(q==0);
//   commit_ptr++ on push. Sustains 1 word/cycle with out_ready held high.
// - Returned word ==0: -> DRAIN. Any read issued in that same cycle is in flight.
// - DRAIN (1 cycle): discard in-flight return (no push, no commit); issue_ptr[grant]=commit_ptr[grant];
//   rr=grant+1 mod NUM_IN; -> IDLE. Packet is never interleaved with another input's words.
// - VOQ runs dry mid-packet (issue_ptr==wr_add): stall in STREAM, no timeout; resume when writer advances.
// - Skid FIFO: push and pop same cycle allowed; out_* reflect head; out_valid=!empty; never overflows
//   by construction (credit check counts inflight). out_data holds stable while valid&&!ready.
// - Latency: VOQ non-empty in IDLE -> first out_valid = 3 cycles (grant, read, push).
// - Wrap: pointers ADDR_W wide, increment mod 2**ADDR_W; emptiness by equality only.
// - rams_clear: next edge zeroes all pointers, flushes skid (out_valid=0), drops inflight, FSM IDLE,
//   rr=0. Packet in progress is abandoned without eop; highest priority over all other events.
// - Reset asserted mid-operation: same end state as reset above, immediately (asynchronous).
// TESTING
// - VOQ0 holds {0x1,0xAA,0x0}, out_ready=1 -> out_data 0x1,0xAA,0x0 on 3 consecutive cycles, src=0,
//   eop only on 0x0; commit_ptr[0]=3; rd returns to IDLE.
// - VOQ1 and VOQ3 each hold one 3-word packet, rr=0 -> VOQ1 packet fully, then VOQ3; next rr=0.
// - out_ready low for 10 cycles mid-packet -> out_valid held, out_data stable, <=SKID_DEPTH words
//   buffered, no word lost/duplicated after ready rises.
// - Packet split: writer supplies header then stalls 5 cycles before rest -> arbiter waits, no word
//   from another VOQ interleaved, full packet delivered in order.
// - Pointers start at 4094, 4-word packet -> words read from 4094,4095,0,1; commit_ptr ends at 2.
// - rams_clear pulse mid-packet -> next cycle out_valid=0, all voq_rd_add=0, FSM IDLE; new packet
//   written from address 0 streams normally.

Source files
------------

// File: rtl/voq_output_arbiter.sv
// rtl/voq_output_arbiter.sv - per-output-port VOQ drain arbiter: round-robin whole-packet reads into a skid FIFO
module voq_output_arbiter #(
    parameter int  NUM_IN     = 4,
    parameter int  DATA_W     = 32,
    parameter int  ADDR_W     = 12,
    parameter int  SKID_DEPTH = 4,
    localparam int SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rams_clear,
    input  logic [NUM_IN*ADDR_W-1:0] voq_wr_add,
    input  logic [NUM_IN*DATA_W-1:0] voq_q,
    output logic [NUM_IN*ADDR_W-1:0] voq_rd_add,
    output logic [NUM_IN-1:0]        voq_rden,
    output logic [DATA_W-1:0]        out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic                     out_eop,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int SP_W = $clog2(SKID_DEPTH);
    localparam int SC_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic              eop;
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } skid_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [SRC_W-1:0]  rr_q, rr_d;
    logic              inflight_q, inflight_d;

    logic [ADDR_W-1:0] issue_q  [NUM_IN];
    logic [ADDR_W-1:0] issue_d  [NUM_IN];
    logic [ADDR_W-1:0] commit_q [NUM_IN];
    logic [ADDR_W-1:0] commit_d [NUM_IN];
    logic [ADDR_W-1:0] wr_add   [NUM_IN];
    logic [DATA_W-1:0] rd_word  [NUM_IN];

    logic [SP_W-1:0]   skid_wr_q, skid_wr_d;
    logic [SP_W-1:0]   skid_rd_q, skid_rd_d;
    logic [SC_W-1:0]   skid_cnt_q, skid_cnt_d;
    skid_t             skid_mem [SKID_DEPTH];
    skid_t             skid_head;

    logic              pick_found;
    logic [SRC_W-1:0]  pick_idx;
    logic              issue_avail;
    logic              credit_ok;
    logic              rd_en;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] ret_word;
    logic              ret_eop;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_port
            assign wr_add[g]                       = voq_wr_add[g*ADDR_W +: ADDR_W];
            assign rd_word[g]                      = voq_q[g*DATA_W +: DATA_W];
            assign voq_rd_add[g*ADDR_W +: ADDR_W]  = issue_q[g];
            assign voq_rden[g]                     = rd_en && (grant_q == SRC_W'(g));
        end
    endgenerate

    function automatic logic [SP_W-1:0] skid_next(input logic [SP_W-1:0] p);
        return (p == SP_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan; in IDLE issue==commit so commit!=wr_add is the emptiness test.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(rr_q) + k) % NUM_IN;
            if (!pick_found && (commit_q[idx] != wr_add[idx])) begin
                pick_found = 1'b1;
                pick_idx   = SRC_W'(idx);
            end
        end
    end

    // Credits include the read in flight so a returning word always has a free skid slot.
    assign issue_avail = (issue_q[grant_q] != wr_add[grant_q]);
    assign credit_ok   = (({1'b0, skid_cnt_q} + (SC_W+1)'(inflight_q)) < (SC_W+1)'(SKID_DEPTH));
    assign rd_en       = (state_q == S_STREAM) && issue_avail && credit_ok && !rams_clear;
    assign ret_word    = rd_word[grant_q];
    assign ret_eop     = (ret_word == '0);
    assign push        = (state_q == S_STREAM) && inflight_q;
    assign pop         = (skid_cnt_q != '0) && out_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (push && ret_eop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                rr_d    = (grant_q == SRC_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rams_clear) begin
            state_d = S_IDLE;
            rr_d    = '0;
        end
    end

    // DRAIN rewinds issue to commit, discarding whatever was speculatively read past the terminator.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            issue_d[i]  = issue_q[i];
            commit_d[i] = commit_q[i];
        end
        if (rd_en) begin
            issue_d[grant_q] = issue_q[grant_q] + ADDR_W'(1);
        end
        if (push) begin
            commit_d[grant_q] = commit_q[grant_q] + ADDR_W'(1);
        end
        if (state_q == S_DRAIN) begin
            issue_d[grant_q] = commit_q[grant_q];
        end
        if (rams_clear) begin
            for (int i = 0; i < NUM_IN; i++) begin
                issue_d[i]  = '0;
                commit_d[i] = '0;
            end
        end
    end

    assign inflight_d = rd_en;

    always_comb begin
        skid_wr_d  = skid_wr_q;
        skid_rd_d  = skid_rd_q;
        skid_cnt_d = skid_cnt_q;
        if (push) begin
            skid_wr_d = skid_next(skid_wr_q);
        end
        if (pop) begin
            skid_rd_d = skid_next(skid_rd_q);
        end
        if (push && !pop) begin
            skid_cnt_d = skid_cnt_q + 1'b1;
        end else if (pop && !push) begin
            skid_cnt_d = skid_cnt_q - 1'b1;
        end
        if (rams_clear) begin
            skid_wr_d  = '0;
            skid_rd_d  = '0;
            skid_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            inflight_q <= 1'b0;
            skid_wr_q  <= '0;
            skid_rd_q  <= '0;
            skid_cnt_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                issue_q[i]  <= '0;
                commit_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            skid_wr_q  <= skid_wr_d;
            skid_rd_q  <= skid_rd_d;
            skid_cnt_q <= skid_cnt_d;
            for (int i = 0; i < NUM_IN; i++) begin
                issue_q[i]  <= issue_d[i];
                commit_q[i] <= commit_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            skid_mem[skid_wr_q] <= '{eop: ret_eop, src: grant_q, data: ret_word};
        end
    end

    assign skid_head = skid_mem[skid_rd_q];
    assign out_valid = (skid_cnt_q != '0);
    assign out_data  = out_valid ? skid_head.data : '0;
    assign out_src   = out_valid ? skid_head.src  : '0;
    assign out_eop   = out_valid ? skid_head.eop  : 1'b0;

endmodule

// File: tb/tb_voq_output_arbiter.sv
// tb/tb_voq_output_arbiter.sv - randomized bench for voq_output_arbiter against a per-VOQ packet scoreboard
module tb_voq_output_arbiter;

    localparam int NI = 4;
    localparam int DW = 32;
    localparam int AW = 12;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             rams_clear;
    logic [NI*AW-1:0] voq_wr_add;
    logic [NI*DW-1:0] voq_q;
    logic [NI*AW-1:0] voq_rd_add;
    logic [NI-1:0]    voq_rden;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src;
    logic             out_eop;
    logic             out_valid;
    logic             out_ready;

    voq_output_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rams_clear (rams_clear),
        .voq_wr_add (voq_wr_add),
        .voq_q      (voq_q),
        .voq_rd_add (voq_rd_add),
        .voq_rden   (voq_rden),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_eop    (out_eop),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [NI][4096];
    logic [AW-1:0] wr  [NI];
    logic [DW-1:0] q_reg [NI];
    logic [DW-1:0] exp_q [NI][$];
    int            starts[$];
    int            rd_log[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            accepted = 0;
    int            rdy_mode = 0;
    bit            mon_en = 0;
    bit            log_en = 0;
    bit            in_pkt = 0;
    bit            hold_pend = 0;
    logic [DW-1:0] hold_data;
    int            cur_src = 0;
    int            mon_s;
    logic [DW-1:0] mon_e;

    assign voq_wr_add = {wr[3], wr[2], wr[1], wr[0]};
    assign voq_q      = {q_reg[3], q_reg[2], q_reg[1], q_reg[0]};

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (voq_rden[i]) q_reg[i] <= ram[i][voq_rd_add[i*AW +: AW]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: each VOQ delivers its own words in write order; a packet is never interleaved.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(hold_data));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                mon_s = int'(out_src);
                if (in_pkt) chk("no_interleave", 64'(mon_s), 64'(cur_src));
                else        starts.push_back(mon_s);
                if (exp_q[mon_s].size() == 0) begin
                    chk("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000);
                end else begin
                    mon_e = exp_q[mon_s].pop_front();
                    chk("data", 64'(out_data), 64'(mon_e));
                    chk("eop", 64'(out_eop), 64'(mon_e == '0));
                end
                in_pkt  = !out_eop;
                cur_src = mon_s;
                accepted++;
            end
        end
    end

    always @(negedge clk) begin
        if (log_en && voq_rden[3]) rd_log.push_back(int'(voq_rd_add[3*AW +: AW]));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_nz();
        logic [DW-1:0] t;
        t = $urandom;
        return (t == '0) ? 32'h1 : t;
    endfunction

    task automatic put_word(input int v, input logic [DW-1:0] w);
        ram[v][wr[v]] = w;
        wr[v] = wr[v] + 1'b1;
        exp_q[v].push_back(w);
    endtask

    task automatic write_pkt(input int v, input int npay);
        logic [DW-1:0] h;
        h = $urandom;
        put_word(v, {h[31:2], 2'b01});
        for (int k = 0; k < npay; k++) put_word(v, rnd_nz());
        put_word(v, '0);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NI; i++) s += exp_q[i].size();
        return s;
    endfunction

    task automatic wait_drain(input int max);
        int n = 0;
        while ((pending() != 0 || out_valid) && n < max) begin
            step(1);
            n++;
        end
        chk("drain_in_time", 64'(n < max), 64'd1);
        step(3);
    endtask

    task automatic wait_accepted(input int cnt);
        int a0 = accepted;
        int n  = 0;
        while (accepted < a0 + cnt && n < 100) begin
            step(1);
            n++;
        end
        chk("accept_in_time", 64'(n < 100), 64'd1);
    endtask

    task automatic expect_latency(input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin
            step(1);
            n++;
        end
        chk(tag, 64'(n), 64'd3);
    endtask

    task automatic flush_model();
        for (int i = 0; i < NI; i++) begin
            wr[i] = '0;
            exp_q[i].delete();
        end
        starts.delete();
        in_pkt    = 0;
        hold_pend = 0;
    endtask

    task automatic clear_pulse();
        mon_en     = 0;
        rams_clear = 1'b1;
        step(1);
        rams_clear = 1'b0;
        flush_model();
        mon_en = 1;
    endtask

    initial begin
        int base2;
        int a0;
        reset_n    = 1'b0;
        rams_clear = 1'b0;
        for (int i = 0; i < NI; i++) begin
            wr[i]    = '0;
            q_reg[i] = '0;
        end
        step(3);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_src_eop", 64'({out_src, out_eop}), 64'd0);
        chk("rst_rden", 64'(voq_rden), 64'd0);
        chk("rst_rd_add", 64'(voq_rd_add), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1;
        step(2);

        put_word(0, 32'h1);
        put_word(0, 32'hAA);
        put_word(0, 32'h0);
        expect_latency("latency_voq0");
        chk("w0_data", 64'({out_src, out_eop, out_data}), 64'({2'd0, 1'b0, 32'h1}));
        step(1);
        chk("w1_data", 64'({out_valid, out_src, out_eop, out_data}), 64'({1'b1, 2'd0, 1'b0, 32'hAA}));
        step(1);
        chk("w2_data", 64'({out_valid, out_src, out_eop, out_data}), 64'({1'b1, 2'd0, 1'b1, 32'h0}));
        step(1);
        chk("after_pkt_valid", 64'(out_valid), 64'd0);
        step(2);
        chk("commit_voq0", 64'(voq_rd_add[0 +: AW]), 64'd3);

        clear_pulse();
        write_pkt(1, 1);
        write_pkt(3, 1);
        wait_drain(200);
        chk("rr_pair_n", 64'(starts.size()), 64'd2);
        if (starts.size() >= 2) begin
            chk("rr_first", 64'(starts[0]), 64'd1);
            chk("rr_second", 64'(starts[1]), 64'd3);
        end
        starts.delete();
        write_pkt(2, 1);
        write_pkt(0, 1);
        wait_drain(200);
        chk("rr_wrapped_n", 64'(starts.size()), 64'd2);
        if (starts.size() >= 2) chk("rr_wrapped_first", 64'(starts[0]), 64'd0);

        base2 = int'(voq_rd_add[2*AW +: AW]);
        write_pkt(2, 10);
        a0 = accepted;
        wait_accepted(2);
        rdy_mode = 2;
        step(11);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("skid_fill", 64'(int'(voq_rd_add[2*AW +: AW]) - base2 - (accepted - a0)), 64'd4);
        rdy_mode = 0;
        wait_drain(200);

        starts.delete();
        put_word(0, 32'h5);
        step(2);
        write_pkt(1, 2);
        step(3);
        put_word(0, 32'h11);
        put_word(0, 32'h22);
        put_word(0, 32'h33);
        put_word(0, 32'h0);
        wait_drain(200);
        chk("split_n", 64'(starts.size()), 64'd2);
        if (starts.size() >= 2) begin
            chk("split_first", 64'(starts[0]), 64'd0);
            chk("split_second", 64'(starts[1]), 64'd1);
        end

        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            write_pkt($urandom_range(0, 3), $urandom_range(0, 6));
            step($urandom_range(0, 8));
        end
        wait_drain(3000);
        rdy_mode = 0;

        clear_pulse();
        write_pkt(3, 4092);
        wait_drain(6000);
        chk("wrap_start", 64'(voq_rd_add[3*AW +: AW]), 64'd4094);
        rd_log.delete();
        log_en = 1;
        write_pkt(3, 2);
        wait_drain(200);
        log_en = 0;
        chk("wrap_reads_n", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() >= 4) begin
            chk("wrap_rd0", 64'(rd_log[0]), 64'd4094);
            chk("wrap_rd1", 64'(rd_log[1]), 64'd4095);
            chk("wrap_rd2", 64'(rd_log[2]), 64'd0);
            chk("wrap_rd3", 64'(rd_log[3]), 64'd1);
        end
        chk("wrap_commit", 64'(voq_rd_add[3*AW +: AW]), 64'd2);

        write_pkt(1, 20);
        wait_accepted(3);
        clear_pulse();
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_rd_add", 64'(voq_rd_add), 64'd0);
        chk("clr_rden", 64'(voq_rden), 64'd0);
        write_pkt(2, 2);
        expect_latency("latency_after_clear");
        wait_drain(200);

        write_pkt(0, 15);
        wait_accepted(3);
        mon_en = 0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_rd", 64'({voq_rden, voq_rd_add}), 64'd0);
        flush_model();
        step(1);
        reset_n = 1'b1;
        mon_en  = 1;
        step(1);
        write_pkt(3, 1);
        expect_latency("latency_after_reset");
        wait_drain(200);

        for (int i = 0; i < NI; i++) chk("leftover", 64'(exp_q[i].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
